// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU op encodings, flag bit positions,
// FSM state encoding and the flag packing helper.
package alu_share_arbiter_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;

  // Bit positions inside the 4-bit {zero,overflow,carryOut,negative} flag vector.
  localparam int FLAG_ZERO     = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_NEGATIVE = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic zero, input logic overflow,
                                            input logic carry, input logic negative);
    logic [3:0] f;
    f                = 4'b0000;
    f[FLAG_ZERO]     = zero;
    f[FLAG_OVERFLOW] = overflow;
    f[FLAG_CARRY]    = carry;
    f[FLAG_NEGATIVE] = negative;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port.
// The arbiter uses the slave modport; the surrounding logic (or bench) uses master.
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
);
  logic              req0_valid, req0_ready;
  logic [WIDTH-1:0]  req0_a, req0_b;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid, req1_ready;
  logic [WIDTH-1:0]  req1_a, req1_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_zero, alu_overflow, alu_carryOut, alu_negative;

  logic              rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0]  rsp_result;
  logic [3:0]        rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, output req1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero, alu_overflow, alu_carryOut, alu_negative,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, input rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, input req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, input req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero, alu_overflow, alu_carryOut, alu_negative,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins; on a tie the one that did not
// win last time wins. Purely combinational, one-hot or zero grant.
module alu_share_arbiter_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  // NOTE: every output of an always_comb gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin accept in IDLE,
// registered operands during EXEC, registered result/flags/id held in RESP until taken.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_share_arbiter_if.slave  bus,
  output logic                busy,
  output logic [15:0]         op_count
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [15:0]       op_count_q, op_count_d;
  logic [1:0]        grant;
  logic              accept_en;

  alu_share_arbiter_rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is offered only in IDLE and never while reset is asserted.
  assign accept_en      = (state_q == ST_IDLE) && reset_n;
  assign bus.req0_ready = accept_en && grant[0];
  assign bus.req1_ready = accept_en && grant[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          alu_a_d      = grant[1] ? bus.req1_a    : bus.req0_a;
          alu_b_d      = grant[1] ? bus.req1_b    : bus.req0_b;
          alu_ctrl_d   = grant[1] ? bus.req1_ctrl : bus.req0_ctrl;
          id_d         = grant[1];
          last_grant_d = grant[1];
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = bus.alu_result;
        rsp_flags_d  = pack_flags(bus.alu_zero, bus.alu_overflow,
                                  bus.alu_carryOut, bus.alu_negative);
        rsp_id_d     = id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours. Datapath registers are reset too, because the
  // outputs they drive are defined as zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign busy           = (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 32-bit AND/OR/ADD/SUB ALU slice
// closing the loop; expected values are hand-computed constants.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        busy;
  logic [15:0] op_count;
  int          checks;
  int          failures;

  alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(3)) bus ();

  alu_share_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU slice fed from the arbiter's registered operands.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum          = 33'd0;
    bus.alu_result   = 32'd0;
    bus.alu_carryOut = 1'b0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_ctrl)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result   = alu_sum[31:0];
        bus.alu_carryOut = alu_sum[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      ALU_SUB: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_result   = alu_sum[31:0];
        bus.alu_carryOut = alu_sum[32];
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero     = (bus.alu_result == 32'd0);
    bus.alu_negative = bus.alu_result[31];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    reset_n        = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'd0;
    bus.req0_b     = 32'd0;
    bus.req0_ctrl  = ALU_OR;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 32'd0;
    bus.req1_b     = 32'd0;
    bus.req1_ctrl  = ALU_OR;
    bus.rsp_ready  = 1'b1;

    // Reset held for two edges with req0 asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("rst_rsp_valid",  64'(bus.rsp_valid),  64'd0);
    check("rst_op_count",   64'(op_count),       64'd0);
    check("rst_busy",       64'(busy),           64'd0);
    check("rst_alu_a",      64'(bus.alu_a),      64'd0);

    // Single op from req0: OR 0x4F | 0x1B.
    reset_n        = 1'b1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h0000_004F;
    bus.req0_b     = 32'h0000_001B;
    bus.req0_ctrl  = ALU_OR;
    #1;
    check("single_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'b01);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("single_exec_busy",  64'(busy),          64'd1);
    check("single_exec_valid", 64'(bus.rsp_valid), 64'd0);
    check("single_alu_a",      64'(bus.alu_a),     64'h4F);
    check("single_alu_b",      64'(bus.alu_b),     64'h1B);
    check("single_alu_ctrl",   64'(bus.alu_ctrl),  64'(ALU_OR));
    @(negedge clk);
    check("single_rsp_valid",  64'(bus.rsp_valid),  64'd1);
    check("single_rsp_id",     64'(bus.rsp_id),     64'd0);
    check("single_rsp_result", 64'(bus.rsp_result), 64'h5F);
    check("single_rsp_flags",  64'(bus.rsp_flags),  64'b0000);
    check("single_cnt_before", 64'(op_count),       64'd0);
    @(negedge clk);
    check("single_rsp_drop", 64'(bus.rsp_valid), 64'd0);
    check("single_op_count", 64'(op_count),      64'd1);
    check("single_idle",     64'(busy),          64'd0);

    // Contention from a fresh reset: grants go 0,1,0,1.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n        = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'd1;
    bus.req0_b     = 32'd2;
    bus.req0_ctrl  = ALU_ADD;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'hD500_0000;
    bus.req1_b     = 32'h2500_0000;
    bus.req1_ctrl  = ALU_OR;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 64'({bus.req1_ready, bus.req0_ready}), (k % 2 == 0) ? 64'b01 : 64'b10);
      @(negedge clk);
      @(negedge clk);
      check("rr_rsp_id",     64'(bus.rsp_id),     64'(k % 2));
      check("rr_rsp_result", 64'(bus.rsp_result), (k % 2 == 0) ? 64'h3 : 64'hF500_0000);
      check("rr_rsp_flags",  64'(bus.rsp_flags),  (k % 2 == 0) ? 64'b0000 : 64'b0001);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_op_count", 64'(op_count), 64'd4);

    // Backpressure: response held five cycles with rsp_ready low.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'hFF00_FF00;
    bus.req0_b     = 32'h0FF0_0FF0;
    bus.req0_ctrl  = ALU_AND;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid",  64'(bus.rsp_valid),  64'd1);
      check("bp_rsp_result", 64'(bus.rsp_result), 64'h0F00_0F00);
      check("bp_rsp_id",     64'(bus.rsp_id),     64'd0);
      check("bp_readys",     64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      check("bp_op_count",   64'(op_count),       64'd4);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    check("bp_release_count", 64'(op_count),      64'd5);
    check("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
    check("bp_release_idle",  64'(busy),          64'd0);

    // Reset during EXEC: op dropped, counter cleared, req0 wins the next tie.
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h12;
    bus.req0_b     = 32'h34;
    bus.req0_ctrl  = ALU_ADD;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("mid_exec_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_count", 64'(op_count), 64'd0);
    check("mid_rst_busy",  64'(busy),     64'd0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
    end

    // Zero result: a=b=0 OR, issued as a tie that req0 must win.
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'd0;
    bus.req0_b     = 32'd0;
    bus.req0_ctrl  = ALU_OR;
    bus.req1_valid = 1'b1;
    #1;
    check("post_rst_tie", 64'({bus.req1_ready, bus.req0_ready}), 64'b01);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("zero_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("zero_rsp_flags",  64'(bus.rsp_flags),  64'b1000);
    check("zero_rsp_id",     64'(bus.rsp_id),     64'd0);
    @(negedge clk);
    check("zero_op_count", 64'(op_count), 64'd1);

    // Counter wrap: preload 0xFFFF, next completion wraps to zero.
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    check("wrap_preload", 64'(op_count), 64'hFFFF);
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'hD500_0000;
    bus.req1_b     = 32'h2500_0000;
    bus.req1_ctrl  = ALU_OR;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("wrap_rsp_id",     64'(bus.rsp_id),     64'd1);
    check("wrap_rsp_result", 64'(bus.rsp_result), 64'hF500_0000);
    check("wrap_before",     64'(op_count),       64'hFFFF);
    @(negedge clk);
    check("wrap_op_count",  64'(op_count),      64'd0);
    check("wrap_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
